// File: rtl/ibex_fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Entry bundle, compressed-instruction test and depth limit.
package ibex_fetch_pkg;

    localparam int unsigned MAX_FETCH_DEPTH = 8;
    localparam int unsigned FETCH_ADDR_W    = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [31:0]             rdata;
        logic                    err;
    } fetch_entry_t;

    function automatic logic is_compressed(logic [1:0] lo);
        return lo != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_fetch_align.sv
// Combinational realigner: builds one instruction from head/next words.
// In: head/next data+err+valid, PC[1]. Out: rdata, valid, err, incr4, pop.
module ibex_fetch_align
    import ibex_fetch_pkg::*;
(
    input  logic        unaligned_i,
    input  logic [31:0] head_rdata_i,
    input  logic        head_err_i,
    input  logic        head_valid_i,
    input  logic [31:0] next_rdata_i,
    input  logic        next_err_i,
    input  logic        next_valid_i,
    output logic [31:0] rdata_o,
    output logic        valid_o,
    output logic        err_o,
    output logic        incr4_o,
    output logic        pop_o
);

    logic c_lo;
    logic c_hi;

    assign c_lo = is_compressed(head_rdata_i[1:0]);
    assign c_hi = is_compressed(head_rdata_i[17:16]);

    always_comb begin
        rdata_o = head_rdata_i;
        valid_o = head_valid_i;
        err_o   = head_err_i;
        incr4_o = 1'b1;
        pop_o   = 1'b1;
        unique case (1'b1)
            !unaligned_i && c_lo: begin
                // upper half still holds the next instruction
                incr4_o = 1'b0;
                pop_o   = 1'b0;
            end
            !unaligned_i && !c_lo: begin
            end
            unaligned_i && c_hi: begin
                rdata_o = {16'h0000, head_rdata_i[31:16]};
                incr4_o = 1'b0;
            end
            unaligned_i && !c_hi: begin
                rdata_o = {next_rdata_i[15:0], head_rdata_i[31:16]};
                // a faulting first half is reported without its partner
                valid_o = head_valid_i & (next_valid_i | head_err_i);
                err_o   = head_err_i | (next_valid_i & next_err_i);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ibex_fetch_queue.sv
// Fetch queue between memory responses and the IF instruction register.
// In: clk/rst, clear, in_* word stream, out_ready. Out: instr, occupancy.
module ibex_fetch_queue
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter bit          ALIGN_EN = 1'b1,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic [ADDR_W-1:0]          in_addr_i,
    input  logic [31:0]                in_rdata_i,
    input  logic                       in_err_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_rdata_o,
    output logic [ADDR_W-1:0]          out_addr_o,
    output logic                       out_err_o,
    output logic                       out_valid_stored_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 3 || DEPTH > MAX_FETCH_DEPTH) begin : gen_bad_depth
        $error("ibex_fetch_queue: DEPTH must be 3..8");
    end
    if (ADDR_W < 2 || ADDR_W > FETCH_ADDR_W) begin : gen_bad_addr_w
        $error("ibex_fetch_queue: ADDR_W must be 2..32");
    end

    fetch_entry_t      entries_q [DEPTH];
    fetch_entry_t      entries_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    // head PC is implied once the first word after clear is seen
    logic              addr_known_q;
    logic              addr_known_d;

    logic [ADDR_W-1:0] head_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [31:0]       head_rdata;
    logic              head_err;
    logic              head_vld;
    logic [31:0]       next_rdata;
    logic              next_err;
    logic              next_vld;
    logic              incr4;
    logic              pop;
    logic              accept;
    logic              push_done;

    assign head_addr  = (ALIGN_EN ? addr_known_q : valid_q[0]) ?
                        ADDR_W'(entries_q[0].addr) : in_addr_i;
    assign head_rdata = valid_q[0] ? entries_q[0].rdata : in_rdata_i;
    assign head_err   = valid_q[0] ? entries_q[0].err : in_err_i;
    assign head_vld   = valid_q[0] | in_valid_i;
    assign next_rdata = valid_q[1] ? entries_q[1].rdata : in_rdata_i;
    assign next_err   = valid_q[1] ? entries_q[1].err : in_err_i;
    assign next_vld   = valid_q[1] | (valid_q[0] & in_valid_i);

    if (ALIGN_EN) begin : gen_align
        ibex_fetch_align u_align (
            .unaligned_i  (head_addr[1]),
            .head_rdata_i (head_rdata),
            .head_err_i   (head_err),
            .head_valid_i (head_vld),
            .next_rdata_i (next_rdata),
            .next_err_i   (next_err),
            .next_valid_i (next_vld),
            .rdata_o      (out_rdata_o),
            .valid_o      (out_valid_o),
            .err_o        (out_err_o),
            .incr4_o      (incr4),
            .pop_o        (pop)
        );
        assign out_valid_stored_o = valid_q[0] &
            (~entries_q[0].addr[1] |
             is_compressed(entries_q[0].rdata[17:16]) |
             valid_q[1] | entries_q[0].err);
    end else begin : gen_no_align
        assign out_rdata_o        = head_rdata;
        assign out_valid_o        = head_vld;
        assign out_err_o          = head_err;
        assign incr4              = 1'b1;
        assign pop                = 1'b1;
        assign out_valid_stored_o = valid_q[0];
    end

    assign out_addr_o = head_addr;
    assign in_ready_o = ~valid_q[DEPTH-2];
    assign accept     = out_valid_o & out_ready_i;
    assign addr_inc   = incr4 ? ADDR_W'(4) : ADDR_W'(2);

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy_o = occupancy_o + OCC_W'(valid_q[k]);
        end
    end

    // push into the post-state first, then pop from the result
    always_comb begin
        entries_d    = entries_q;
        valid_d      = valid_q;
        addr_known_d = addr_known_q | in_valid_i;
        push_done    = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (in_valid_i && !valid_q[k] && !push_done) begin
                push_done          = 1'b1;
                valid_d[k]         = 1'b1;
                entries_d[k].rdata = in_rdata_i;
                entries_d[k].err   = in_err_i;
                if (!ALIGN_EN || k != 0 || !addr_known_q) begin
                    entries_d[k].addr = FETCH_ADDR_W'(in_addr_i);
                end
            end
        end
        if (accept) begin
            if (pop) begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    entries_d[k] = entries_d[k+1];
                    valid_d[k]   = valid_d[k+1];
                end
                valid_d[DEPTH-1] = 1'b0;
            end
            if (ALIGN_EN) begin
                entries_d[0].addr = FETCH_ADDR_W'(head_addr + addr_inc);
            end
        end
        if (clear_i) begin
            valid_d      = '0;
            addr_known_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_q[k] <= '0;
            end
            valid_q      <= '0;
            addr_known_q <= 1'b0;
        end else begin
            entries_q    <= entries_d;
            valid_q      <= valid_d;
            addr_known_q <= addr_known_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i && valid_q[DEPTH-1] && !clear_i));

endmodule

// File: tb/tb_ibex_fetch_queue.sv
// Directed bench for ibex_fetch_queue: aligned (DEPTH=3) and
// pre-aligned (DEPTH=4, ALIGN_EN=0) instances with output scoreboards.
module tb_ibex_fetch_queue;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] mask;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        clear     [2];
    logic        in_valid  [2];
    logic        in_err    [2];
    logic        out_ready [2];
    logic [31:0] in_addr   [2];
    logic [31:0] in_rdata  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_err   [2];
    logic        out_vs    [2];
    logic [31:0] out_rdata [2];
    logic [31:0] out_addr  [2];
    logic [1:0]  occ_a;
    logic [2:0]  occ_b;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    ibex_fetch_queue u_dut_a (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear[0]),
        .in_addr_i          (in_addr[0]),
        .in_rdata_i         (in_rdata[0]),
        .in_err_i           (in_err[0]),
        .in_valid_i         (in_valid[0]),
        .in_ready_o         (in_ready[0]),
        .out_valid_o        (out_valid[0]),
        .out_ready_i        (out_ready[0]),
        .out_rdata_o        (out_rdata[0]),
        .out_addr_o         (out_addr[0]),
        .out_err_o          (out_err[0]),
        .out_valid_stored_o (out_vs[0]),
        .occupancy_o        (occ_a)
    );

    ibex_fetch_queue #(
        .DEPTH    (4),
        .ALIGN_EN (1'b0)
    ) u_dut_b (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear[1]),
        .in_addr_i          (in_addr[1]),
        .in_rdata_i         (in_rdata[1]),
        .in_err_i           (in_err[1]),
        .in_valid_i         (in_valid[1]),
        .in_ready_o         (in_ready[1]),
        .out_valid_o        (out_valid[1]),
        .out_ready_i        (out_ready[1]),
        .out_rdata_o        (out_rdata[1]),
        .out_addr_o         (out_addr[1]),
        .out_err_o          (out_err[1]),
        .out_valid_stored_o (out_vs[1]),
        .occupancy_o        (occ_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input int d, input logic [31:0] rdata,
                              input logic [31:0] mask,
                              input logic [31:0] addr, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.mask  = mask;
        e.addr  = addr;
        e.err   = err;
        if (d == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic check_out(input int d);
        exp_t e;
        int   sz;
        sz = (d == 0) ? sb0.size() : sb1.size();
        n_chk++;
        assert (sz != 0) else begin
            n_fail++;
            $error("FAIL sb_underflow_%0d: observed %0h expected none",
                   d, out_rdata[d]);
        end
        if (sz != 0) begin
            if (d == 0) e = sb0.pop_front();
            else e = sb1.pop_front();
            chk($sformatf("out_rdata_%0d", d),
                out_rdata[d] & e.mask, e.rdata & e.mask);
            chk($sformatf("out_addr_%0d", d), out_addr[d], e.addr);
            chk($sformatf("out_err_%0d", d), out_err[d], e.err);
        end
    endtask

    // one cycle: drive at negedge, sample 1ns later, commit at posedge
    task automatic step(input int d, input logic clr, input logic vld,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic err, input logic rdy);
        @(negedge clk);
        clear[d]     = clr;
        in_valid[d]  = vld;
        in_addr[d]   = addr;
        in_rdata[d]  = data;
        in_err[d]    = err;
        out_ready[d] = rdy;
        #1;
        if (out_valid[d] && out_ready[d]) check_out(d);
        if (clr) begin
            if (d == 0) sb0.delete();
            else sb1.delete();
        end
    endtask

    task automatic idle(input int d, input logic rdy);
        step(d, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    task automatic do_clear(input int d);
        step(d, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            clear[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            in_err[d]    = 1'b0;
            out_ready[d] = 1'b0;
            in_addr[d]   = 32'h0;
            in_rdata[d]  = 32'h0;
        end
        @(negedge clk);
        #1;
        chk("rst_a_valid", out_valid[0], 0);
        chk("rst_a_vs", out_vs[0], 0);
        chk("rst_a_in_ready", in_ready[0], 1);
        chk("rst_a_occ", occ_a, 0);
        chk("rst_b_valid", out_valid[1], 0);
        chk("rst_b_in_ready", in_ready[1], 1);
        chk("rst_b_occ", occ_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // zero-latency bypass from reset
        expect_out(0, 32'h00A00093, 32'hFFFFFFFF, 32'h80, 1'b0);
        step(0, 1'b0, 1'b1, 32'h80, 32'h00A00093, 1'b0, 1'b1);
        chk("t1_bypass_valid", out_valid[0], 1);
        idle(0, 1'b0);
        chk("t1_occ", occ_a, 0);
        chk("t1_valid_after", out_valid[0], 0);

        // two compressed instructions in one word
        do_clear(0);
        expect_out(0, 32'h4505, 32'hFFFF, 32'h100, 1'b0);
        expect_out(0, 32'h4501, 32'hFFFF, 32'h102, 1'b0);
        step(0, 1'b0, 1'b1, 32'h100, 32'h45014505, 1'b0, 1'b1);
        idle(0, 1'b1);
        chk("t2_occ_mid", occ_a, 1);
        idle(0, 1'b0);
        chk("t2_occ_end", occ_a, 0);
        chk("t2_valid_end", out_valid[0], 0);

        // 32-bit instruction straddling two words
        do_clear(0);
        expect_out(0, 32'h4505, 32'hFFFF, 32'h200, 1'b0);
        expect_out(0, 32'h00A00093, 32'hFFFFFFFF, 32'h202, 1'b0);
        expect_out(0, 32'h0005, 32'hFFFF, 32'h206, 1'b0);
        step(0, 1'b0, 1'b1, 32'h200, 32'h00934505, 1'b0, 1'b1);
        idle(0, 1'b1);
        chk("t3_wait_valid", out_valid[0], 0);
        chk("t3_wait_vs", out_vs[0], 0);
        chk("t3_wait_occ", occ_a, 1);
        step(0, 1'b0, 1'b1, 32'h204, 32'h000500A0, 1'b0, 1'b1);
        chk("t3_join_valid", out_valid[0], 1);
        chk("t3_join_vs", out_vs[0], 0);
        idle(0, 1'b1);
        chk("t3_tail_vs", out_vs[0], 1);
        idle(0, 1'b0);
        chk("t3_occ_end", occ_a, 0);

        // PC wraps; later word's address is implied
        do_clear(0);
        expect_out(0, 32'h00A00093, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0);
        expect_out(0, 32'h00B00113, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        step(0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00A00093, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1, 32'h00001234, 32'h00B00113, 1'b0, 1'b1);
        idle(0, 1'b0);
        chk("t4_occ_end", occ_a, 0);

        // clear while two entries are held
        do_clear(0);
        expect_out(0, 32'h00A00093, 32'hFFFFFFFF, 32'h300, 1'b0);
        expect_out(0, 32'h00B00113, 32'hFFFFFFFF, 32'h304, 1'b0);
        step(0, 1'b0, 1'b1, 32'h300, 32'h00A00093, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 32'h304, 32'h00B00113, 1'b0, 1'b0);
        idle(0, 1'b0);
        chk("t5_occ_held", occ_a, 2);
        chk("t5_in_ready_full", in_ready[0], 0);
        chk("t5_vs_held", out_vs[0], 1);
        step(0, 1'b1, 1'b1, 32'h500, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("t5_in_ready_clear", in_ready[0], 0);
        expect_out(0, 32'h00C00193, 32'hFFFFFFFF, 32'h400, 1'b0);
        step(0, 1'b0, 1'b1, 32'h400, 32'h00C00193, 1'b0, 1'b1);
        chk("t5_occ_after", occ_a, 0);
        chk("t5_valid_new", out_valid[0], 1);
        idle(0, 1'b0);

        // error on the second half of a straddling instruction
        do_clear(0);
        expect_out(0, 32'h4505, 32'hFFFF, 32'h500, 1'b0);
        expect_out(0, 32'h00A00093, 32'hFFFFFFFF, 32'h502, 1'b1);
        expect_out(0, 32'h0005, 32'hFFFF, 32'h506, 1'b1);
        step(0, 1'b0, 1'b1, 32'h500, 32'h00934505, 1'b0, 1'b1);
        idle(0, 1'b1);
        chk("t6_wait_valid", out_valid[0], 0);
        step(0, 1'b0, 1'b1, 32'h504, 32'h000500A0, 1'b1, 1'b1);
        chk("t6_err_valid", out_valid[0], 1);
        chk("t6_err", out_err[0], 1);
        idle(0, 1'b1);
        idle(0, 1'b0);

        // error on the first half alone is enough to present it
        do_clear(0);
        expect_out(0, 32'h4505, 32'hFFFF, 32'h600, 1'b1);
        expect_out(0, 32'h0093, 32'hFFFF, 32'h602, 1'b1);
        step(0, 1'b0, 1'b1, 32'h600, 32'h00934505, 1'b1, 1'b1);
        idle(0, 1'b1);
        chk("t7_head_err_valid", out_valid[0], 1);
        chk("t7_head_err_vs", out_vs[0], 1);
        idle(0, 1'b0);
        chk("t7_occ_end", occ_a, 0);

        // pre-aligned queue: bypass
        expect_out(1, 32'h00A00093, 32'hFFFFFFFF, 32'h80, 1'b0);
        step(1, 1'b0, 1'b1, 32'h80, 32'h00A00093, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("b1_occ", occ_b, 0);

        // backpressure to full, then drain with a push-and-pop cycle
        expect_out(1, 32'h45014505, 32'hFFFFFFFF, 32'h10, 1'b0);
        expect_out(1, 32'h00B00113, 32'hFFFFFFFF, 32'h40, 1'b1);
        expect_out(1, 32'h00C00193, 32'hFFFFFFFF, 32'h24, 1'b0);
        expect_out(1, 32'h12345678, 32'hFFFFFFFF, 32'h1000, 1'b0);
        expect_out(1, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h80, 1'b0);
        step(1, 1'b0, 1'b1, 32'h10, 32'h45014505, 1'b0, 1'b0);
        step(1, 1'b0, 1'b1, 32'h40, 32'h00B00113, 1'b1, 1'b0);
        chk("b2_in_ready_1", in_ready[1], 1);
        step(1, 1'b0, 1'b1, 32'h24, 32'h00C00193, 1'b0, 1'b0);
        chk("b2_in_ready_2", in_ready[1], 1);
        idle(1, 1'b0);
        chk("b2_in_ready_3", in_ready[1], 0);
        chk("b2_occ_3", occ_b, 3);
        chk("b2_vs", out_vs[1], 1);
        step(1, 1'b0, 1'b1, 32'h1000, 32'h12345678, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("b2_occ_4", occ_b, 4);
        idle(1, 1'b1);
        step(1, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 1'b1);
        chk("b2_occ_pre_pp", occ_b, 3);
        idle(1, 1'b1);
        chk("b2_occ_post_pp", occ_b, 3);
        idle(1, 1'b1);
        idle(1, 1'b1);
        idle(1, 1'b0);
        chk("b2_occ_end", occ_b, 0);
        chk("b2_valid_end", out_valid[1], 0);

        chk("sb_a_drained", sb0.size(), 0);
        chk("sb_b_drained", sb1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
